seq_shifter: RTL and testbench
==============================

# seq_shifter

Multi-cycle 64-bit shift/rotate unit for the datapath, complementing the fixed left-shift-by-2 used for branch offsets. It accepts an operand, a shift amount and an operation (LSL, LSR, ASR, ROR) through a start/ready handshake. It shifts up to STEP bit positions per cycle and pulses done with the result held stable. It sits beside the ALU and serves shift-type instructions (LSL/LSR/ASR immediate forms) that stall the EX stage until done.

## Interface
- WIDTH, 64, operand/result width; power of two, ≥ 8.
- STEP, 4, maximum bit positions shifted per cycle; power of two, 1..WIDTH.
- SHW (localparam), $clog2(WIDTH), width of the shift amount.

- clk  input  1  rising-edge clock, single clock domain.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request; accepted on a rising edge when ready=1.
- op  input  2  shift_op_t: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- in_data  input  WIDTH  operand, sampled on accept.
- shamt  input  SHW  shift amount 0..WIDTH-1, sampled on accept.
- ready  output  1  high when state is IDLE or DONE.
- busy  output  1  high when state is SHIFT.
- done  output  1  one-cycle pulse; result is valid.
- result  output  WIDTH  result register.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE or DONE with start=1 at an edge:
  - Load the data register with in_data, the remaining counter with shamt, and latch op.
  - Next state is DONE if shamt=0, else SHIFT.
- IDLE with start=0: stay. DONE with start=0: go to IDLE.
- SHIFT, at each edge:
  - Shift the data register by n = min(STEP, remaining) and subtract n from remaining.
  - If the new remaining is 0, go to DONE; otherwise stay in SHIFT.
- Fill rules per n-bit step:
  - LSL fills the LSBs with 0.
  - LSR fills the MSBs with 0.
  - ASR fills the MSBs with the current bit WIDTH-1.
  - ROR wraps the LSBs into the MSBs.
- Composing steps must equal a single shift by shamt. For ASR, repeated sign fill is exact. For ROR, shamt < WIDTH, so there is no double wrap.
- result is driven directly from the data register. It holds its value from DONE until the next accepted start.
- start while busy=1 is ignored: no capture, no effect on the operation in flight.
- start in the DONE cycle is accepted (back-to-back). done is still high that cycle, and result changes at the following edge.
- Out-of-range values cannot occur: shamt is SHW bits wide.

## Timing
- Reset (async assert, reset_n=0): state=IDLE, data=0, remaining=0, op=LSL. Outputs: ready=1, busy=0, done=0, result=0. Deassertion takes effect synchronously at the next edge.
- Reset asserted mid-SHIFT aborts immediately; no done is produced.
- Latency: with start accepted at edge E and k = ceil(shamt/STEP), done is high during the cycle after edge E+k.
  - shamt=0: done in the cycle right after acceptance.
  - Worst case (WIDTH=64, STEP=4, shamt=63): k=16.
- done is high for exactly one cycle per accepted request.
- busy is high for exactly k cycles.
- ready is combinational from state only, with no input-to-output paths.

## Structure
- shift_pkg:
  - shift_op_t enum (SH_LSL, SH_LSR, SH_ASR, SH_ROR).
  - shift_state_t enum (ST_IDLE, ST_SHIFT, ST_DONE).
- Sub-module shift_step:
  - Purely combinational, parameterised on WIDTH/STEP.
  - Inputs: data, op, n (0..STEP). Output: data shifted by n under op.
  - Instantiated once, on the data register's next-value path.
- seq_shifter holds the FSM, the counter and the registers.

## Test plan
All scenarios use WIDTH=64, STEP=4.
- LSL, in_data=1, shamt=2 → result=4, done one cycle after edge E+1, busy high for 1 cycle.
- LSR, in_data=0x8000_0000_0000_0000, shamt=63 → result=1, busy high 16 cycles, done pulse 1 cycle.
- ASR, in_data=0xF000_0000_0000_0000, shamt=9 → result=0xFFF8_0000_0000_0000 after k=3. Also ASR 0x7000_0000_0000_0000 by 9 → 0x0038_0000_0000_0000.
- ROR, in_data=0x0000_0000_0000_00A5, shamt=8 → result=0xA500_0000_0000_0000.
- shamt=0, in_data=0x1234 → result=0x1234 and done the cycle after accept. Then:
  - start pulsed during a SHIFT with different data is ignored, and the original result is returned.
  - start asserted in the DONE cycle is accepted back-to-back.
- reset_n driven low mid-SHIFT (between edges) → result=0, busy=0, ready=1 immediately, with no done. After release, a new request completes normally.

Source files
------------

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared enums for the sequential shift/rotate unit
package shift_pkg;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } shift_state_t;

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational shift/rotate of a word by 0..STEP positions
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int STEP  = 4,
  localparam int NW   = $clog2(STEP + 1),
  localparam int AW   = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic [1:0]       op,
  input  logic [NW-1:0]    n,
  output logic [WIDTH-1:0] shifted
);

  logic [AW-1:0] lsh;

  // Apply one n-bit step; ROR uses WIDTH-n left shift, which yields 0 when n=0
  always_comb begin
    lsh = AW'(WIDTH) - AW'(n);
    case (shift_op_t'(op))
      SH_LSL:  shifted = data << n;
      SH_LSR:  shifted = data >> n;
      SH_ASR:  shifted = $unsigned($signed(data) >>> n);
      default: shifted = (data >> n) | (data << lsh);
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// rtl/seq_shifter.sv - multi-cycle shift/rotate unit with start/ready handshake
module seq_shifter
  import shift_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int STEP  = 4,
  localparam int SHW  = $clog2(WIDTH),
  localparam int NW   = $clog2(STEP + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   shamt,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  shift_state_t   state;
  shift_op_t      op_q;
  logic [WIDTH-1:0] data_q;
  logic [SHW-1:0] rem_q;
  logic [SHW:0]   rem_ext;
  logic [NW-1:0]  n;
  logic [WIDTH-1:0] step_out;

  // Bits to move this cycle: the smaller of STEP and what is left
  always_comb begin
    rem_ext = {1'b0, rem_q};
    if (rem_ext < (SHW+1)'(STEP)) begin
      n = NW'(rem_ext);
    end else begin
      n = NW'(STEP);
    end
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .data    (data_q),
    .op      (op_q),
    .n       (n),
    .shifted (step_out)
  );

  // Handshake FSM, remaining-count and data register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      data_q <= '0;
      rem_q  <= '0;
      op_q   <= SH_LSL;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            data_q <= in_data;
            rem_q  <= shamt;
            op_q   <= shift_op_t'(op);
            state  <= (shamt == '0) ? ST_DONE : ST_SHIFT;
          end else begin
            state  <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          data_q <= step_out;
          rem_q  <= rem_q - SHW'(n);
          if (rem_q == SHW'(n)) begin
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ready  = (state == ST_IDLE) || (state == ST_DONE);
  assign busy   = (state == ST_SHIFT);
  assign done   = (state == ST_DONE);
  assign result = data_q;

endmodule

// File: tb/tb_seq_shifter.sv
// tb/tb_seq_shifter.sv - directed self-checking bench for seq_shifter
module tb_seq_shifter;
  import shift_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [63:0] in_data;
  logic [5:0]  shamt;
  logic        ready;
  logic        busy;
  logic        done;
  logic [63:0] result;

  int n_checks = 0;
  int n_fails  = 0;

  seq_shifter #(.WIDTH(64), .STEP(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .in_data (in_data),
    .shamt   (shamt),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic [63:0] d,
                     input logic [5:0] s, input logic [63:0] exp, input int k,
                     input bit poke, input bit b2b);
    int cycles;
    int busy_cnt;
    cycles   = 0;
    busy_cnt = 0;
    @(negedge clk);
    start   = 1'b1;
    op      = o;
    in_data = d;
    shamt   = s;
    @(posedge clk);
    #1;
    start   = 1'b0;
    op      = ~o;
    in_data = ~d;
    shamt   = ~s;
    while (done !== 1'b1 && cycles < 40) begin
      if (busy === 1'b1) busy_cnt++;
      if (poke && cycles == 0) begin
        start   = 1'b1;
        in_data = 64'hDEAD_BEEF_0000_0000;
        shamt   = 6'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      cycles++;
    end
    start = 1'b0;
    check({tag, " latency"}, 64'(cycles), 64'(k));
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(k));
    check({tag, " result"}, result, exp);
    check({tag, " ready_in_done"}, 64'(ready), 64'd1);
    if (!b2b) begin
      @(posedge clk);
      #1;
      check({tag, " done_one_cycle"}, 64'(done), 64'd0);
      check({tag, " result_held"}, result, exp);
      check({tag, " ready_idle"}, 64'(ready), 64'd1);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    op      = 2'b00;
    in_data = 64'h0;
    shamt   = 6'd0;
    @(posedge clk);
    #1;
    check("reset ready", 64'(ready), 64'd1);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset result", result, 64'h0);
    @(negedge clk);
    reset_n = 1'b1;

    run("lsl_1_by_2",   SH_LSL, 64'h1, 6'd2, 64'h4, 1, 1'b0, 1'b0);
    run("lsl_3_by_5",   SH_LSL, 64'h3, 6'd5, 64'h60, 2, 1'b0, 1'b0);
    run("lsr_msb_by_63", SH_LSR, 64'h8000_0000_0000_0000, 6'd63, 64'h1, 16, 1'b0, 1'b0);
    run("asr_neg_by_9", SH_ASR, 64'hF000_0000_0000_0000, 6'd9, 64'hFFF8_0000_0000_0000, 3, 1'b0, 1'b0);
    run("asr_pos_by_9", SH_ASR, 64'h7000_0000_0000_0000, 6'd9, 64'h0038_0000_0000_0000, 3, 1'b0, 1'b0);
    run("ror_a5_by_8",  SH_ROR, 64'hA5, 6'd8, 64'hA500_0000_0000_0000, 2, 1'b0, 1'b0);
    run("ror_1_by_63",  SH_ROR, 64'h1, 6'd63, 64'h2, 16, 1'b0, 1'b0);
    run("shamt_zero",   SH_LSL, 64'h1234, 6'd0, 64'h1234, 0, 1'b0, 1'b0);
    run("start_ignored_busy", SH_LSL, 64'h1, 6'd12, 64'h1000, 3, 1'b1, 1'b0);
    run("b2b_first",    SH_ROR, 64'h1234, 6'd0, 64'h1234, 0, 1'b0, 1'b1);
    run("b2b_second",   SH_LSL, 64'hFF, 6'd4, 64'hFF0, 1, 1'b0, 1'b0);

    @(negedge clk);
    start   = 1'b1;
    op      = SH_LSR;
    in_data = 64'hFF00_0000_0000_0000;
    shamt   = 6'd40;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("pre_abort busy", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort ready", 64'(ready), 64'd1);
    check("abort result", result, 64'h0);
    check("abort done", 64'(done), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("abort no_done", 64'(done), 64'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    run("after_reset",  SH_LSR, 64'hFF00_0000_0000_0000, 6'd40, 64'hFF_0000, 10, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
